// File: rtl/dlx_mem_arbiter_pkg.sv
// Shared types and defaults for the DLX memory arbiter slice.
//   mem_arb_state_t : arbiter FSM states
//   mem_gnt_t       : which requester owns the current access
//   rr_pick()       : two-way round-robin grant decision
package dlx_mem_pkg;

    localparam int unsigned DLX_ADDRESS_SIZE = 16;
    localparam int unsigned DLX_WORD_SIZE    = 32;
    localparam int unsigned DLX_TIMEOUT      = 15;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_ACCESS,
        MA_DONE
    } mem_arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } mem_gnt_t;

    // Both requesting: the port that was not granted last wins.
    // A single requester always wins. With no request the result is unused.
    function automatic mem_gnt_t rr_pick(input logic req_if, input logic req_dm,
                                         input mem_gnt_t last);
        if (req_if && req_dm)
            return (last == GNT_IF) ? GNT_DM : GNT_IF;
        else if (req_dm)
            return GNT_DM;
        else
            return GNT_IF;
    endfunction

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Core-side request/ack bundle between the DLX core and the memory arbiter.
//   if_* : fetch port (read only)   req/addr in, ack/rdata/err out
//   dm_* : data port (read/write)   req/we/addr/wdata in, ack/rdata/err out
// modport master : core side (drives requests)
// modport slave  : arbiter side (drives acks)
interface dlx_mem_arbiter_if
    import dlx_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = DLX_ADDRESS_SIZE,
    parameter int unsigned WORD_SIZE    = DLX_WORD_SIZE
) ();

    logic                    if_req;
    logic [ADDRESS_SIZE-1:0] if_addr;
    logic                    if_ack;
    logic [WORD_SIZE-1:0]    if_rdata;
    logic                    if_err;

    logic                    dm_req;
    logic                    dm_we;
    logic [ADDRESS_SIZE-1:0] dm_addr;
    logic [WORD_SIZE-1:0]    dm_wdata;
    logic                    dm_ack;
    logic [WORD_SIZE-1:0]    dm_rdata;
    logic                    dm_err;

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata, dm_err
    );

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata, dm_err
    );

endinterface

// File: rtl/dlx_mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant with a last-grant register.
//   clk, rst     : clock, async active-high reset (last grant = IF, so DM is favoured)
//   i_req_if/dm  : request lines
//   i_update     : record the current grant as "last" (asserted only when a grant is taken)
//   o_gnt        : granted port (valid when o_any)
//   o_any        : at least one request present
module rr_arbiter2
    import dlx_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_req_if,
    input  logic     i_req_dm,
    input  logic     i_update,
    output mem_gnt_t o_gnt,
    output logic     o_any
);

    mem_gnt_t r_last;

    assign o_any = i_req_if | i_req_dm;
    assign o_gnt = rr_pick(i_req_if, i_req_dm, r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= GNT_IF;
        else if (i_update && o_any)
            r_last <= o_gnt;
    end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one single-port memory between the fetch (IF) and
// data (DM) ports of the DLX core.
//   clk, rst          : clock, async active-high reset
//   bus (slave)       : per-port req/ack handshakes, see dlx_mem_arbiter_if
//   mem_addr          : memory ADDRESS (latched request address)
//   mem_enable        : memory ENABLE, high for the whole ACCESS state
//   mem_readnotwrite  : memory READNOTWRITE (1 = read)
//   mem_data          : bidirectional memory data, driven only during write ACCESS
//   mem_data_ready    : memory DATA_READY, ignored outside ACCESS
//   busy              : high whenever the FSM is not IDLE
module dlx_mem_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = DLX_ADDRESS_SIZE,
    parameter int unsigned WORD_SIZE    = DLX_WORD_SIZE,
    parameter int unsigned TIMEOUT      = DLX_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    dlx_mem_arbiter_if.slave        bus,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic                    mem_enable,
    output logic                    mem_readnotwrite,
    inout  wire  [WORD_SIZE-1:0]    mem_data,
    input  logic                    mem_data_ready,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    mem_arb_state_t          r_state, w_next;
    mem_gnt_t                r_gnt, w_gnt;
    logic                    w_any, w_latch, w_ready_hit, w_timeout;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic                    r_we;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WORD_SIZE-1:0]    r_rdata;
    logic [CW-1:0]           r_cnt, w_cnt_inc;
    logic                    r_if_ack, r_dm_ack, r_err;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req_if (bus.if_req),
        .i_req_dm (bus.dm_req),
        .i_update (w_latch),
        .o_gnt    (w_gnt),
        .o_any    (w_any)
    );

    // w_cnt_inc is the number of ACCESS cycles including the current one,
    // so the timeout fires on exactly the TIMEOUT-th cycle. Ready has priority.
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_ready_hit = 1'b0;
        w_timeout   = 1'b0;
        w_cnt_inc   = r_cnt + CW'(1);
        case (r_state)
            MA_IDLE: begin
                if (w_any) begin
                    w_latch = 1'b1;
                    w_next  = MA_ACCESS;
                end
            end
            MA_ACCESS: begin
                if (mem_data_ready) begin
                    w_ready_hit = 1'b1;
                    w_next      = MA_DONE;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_next    = MA_DONE;
                end
            end
            MA_DONE:  w_next = MA_IDLE;
            default:  w_next = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= MA_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= GNT_DM;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                MA_IDLE: begin
                    r_cnt <= '0;
                    if (w_latch) begin
                        r_gnt <= w_gnt;
                        if (w_gnt == GNT_DM) begin
                            r_addr  <= bus.dm_addr;
                            r_we    <= bus.dm_we;
                            r_wdata <= bus.dm_wdata;
                        end else begin
                            r_addr  <= bus.if_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                        end
                    end
                end
                MA_ACCESS: begin
                    r_cnt <= w_cnt_inc;
                    if (w_ready_hit || w_timeout) begin
                        r_if_ack <= (r_gnt == GNT_IF);
                        r_dm_ack <= (r_gnt == GNT_DM);
                        r_err    <= w_timeout;
                        r_rdata  <= (w_ready_hit && !r_we) ? mem_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_enable       = (r_state == MA_ACCESS);
    assign mem_addr         = r_addr;
    assign mem_readnotwrite = ~(mem_enable & r_we);
    assign mem_data         = (mem_enable && r_we) ? r_wdata : 'z;
    assign busy             = (r_state != MA_IDLE);

    assign bus.if_ack   = r_if_ack;
    assign bus.if_err   = r_err & r_if_ack;
    assign bus.if_rdata = r_rdata;
    assign bus.dm_ack   = r_dm_ack;
    assign bus.dm_err   = r_err & r_dm_ack;
    assign bus.dm_rdata = r_rdata;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter: a behavioural memory responder with
// programmable DATA_READY latency, and a reference model of expected grants,
// ack timing, error status and memory contents.
module tb_dlx_mem_arbiter;
    import dlx_mem_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned WW = 32;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dlx_mem_arbiter_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) bus ();

    wire  [WW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_enable;
    logic          mem_readnotwrite;
    logic          mem_data_ready = 1'b0;
    logic          busy;

    logic          mem_drv   = 1'b0;
    logic [WW-1:0] mem_val   = '0;
    logic          probe_drv = 1'b0;
    logic [WW-1:0] probe_val = '0;

    assign mem_data = mem_drv ? mem_val : (probe_drv ? probe_val : 'z);

    dlx_mem_arbiter #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .mem_addr         (mem_addr),
        .mem_enable       (mem_enable),
        .mem_readnotwrite (mem_readnotwrite),
        .mem_data         (mem_data),
        .mem_data_ready   (mem_data_ready),
        .busy             (busy)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] init_word(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory environment ----------------
    logic [WW-1:0] env_mem [logic [AW-1:0]];
    int unsigned   mem_lat = 0;
    int unsigned   en_cnt  = 0;
    logic          spur    = 1'b0;

    // Ready is raised in the (mem_lat+1)-th enabled cycle.
    always @(negedge clk) begin
        if (mem_enable) begin
            en_cnt = en_cnt + 1;
            if (en_cnt == mem_lat + 1) begin
                mem_data_ready = 1'b1;
                if (mem_readnotwrite) begin
                    mem_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
                    mem_drv = 1'b1;
                end else begin
                    env_mem[mem_addr] = mem_data;
                end
            end else begin
                mem_data_ready = 1'b0;
                mem_drv        = 1'b0;
            end
        end else begin
            en_cnt         = 0;
            mem_data_ready = spur;
            mem_drv        = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [WW-1:0] ref_mem [logic [AW-1:0]];
    bit            m_last_dm = 1'b0;

    function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int unsigned access_cycles(input int unsigned lat);
        return (lat + 1 <= TO) ? lat + 1 : TO;
    endfunction

    task automatic probe_released(input string tag, input logic [WW-1:0] pat);
        probe_val = pat;
        probe_drv = 1'b1;
        #1;
        chk(tag, mem_data, pat);
        probe_drv = 1'b0;
    endtask

    // One access on one port, with the other port idle.
    task automatic single(input string tag, input bit dm, input bit we,
                          input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                          input int unsigned lat, input bit drop_early);
        int unsigned edges = 0;
        bit got = 0, bad_rnw = 0, bad_addr = 0, bad_wd = 0, bad_other = 0;
        bit exp_err;
        logic [WW-1:0] rdata;
        logic err;
        exp_err = (lat + 1 > TO);
        mem_lat = lat;
        @(negedge clk);
        if (dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        while (!got && edges < 60) begin
            @(negedge clk);
            edges++;
            if (drop_early && edges == 2) begin
                bus.dm_req = 1'b0; bus.if_req = 1'b0;
            end
            if (mem_enable) begin
                if (mem_readnotwrite !== !(dm && we)) bad_rnw = 1;
                if (mem_addr !== addr) bad_addr = 1;
                if (dm && we && mem_data !== wd) bad_wd = 1;
            end
            if ((dm ? bus.if_ack : bus.dm_ack) !== 1'b0) bad_other = 1;
            if ((dm ? bus.dm_ack : bus.if_ack) === 1'b1) got = 1;
        end
        chk({tag, " ack_seen"}, got, 1);
        if (got) begin
            rdata = dm ? bus.dm_rdata : bus.if_rdata;
            err   = dm ? bus.dm_err : bus.if_err;
            chk({tag, " latency"}, edges, access_cycles(lat) + 1);
            chk({tag, " err"}, err, exp_err);
            if (!(dm && we))
                chk({tag, " rdata"}, rdata, exp_err ? '0 : ref_read(addr));
            if (dm && we && !exp_err)
                ref_mem[addr] = wd;
        end
        m_last_dm = dm;
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        chk({tag, " rnw_stable"}, bad_rnw, 0);
        chk({tag, " addr_stable"}, bad_addr, 0);
        if (dm && we) chk({tag, " wdata_on_bus"}, bad_wd, 0);
        chk({tag, " other_ack_quiet"}, bad_other, 0);
        @(negedge clk);
        chk({tag, " ack_one_cycle"}, dm ? bus.dm_ack : bus.if_ack, 0);
        chk({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addrs [4];
        logic [AW-1:0] ra;
        logic [WW-1:0] rw;
        bit rdm, rwe;
        int unsigned rl;
        int unsigned edges, acks, last_edge;
        bit both_bad;
        bit exp_dm;
        logic [AW-1:0] both_if_addr, both_dm_addr;

        addrs[0] = 16'h0010; addrs[1] = 16'h0044; addrs[2] = 16'h0080; addrs[3] = 16'h0081;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset busy", busy, 0);
        chk("reset enable", mem_enable, 0);
        chk("reset rnw", mem_readnotwrite, 1);
        chk("reset addr", mem_addr, 0);
        chk("reset acks", {bus.if_ack, bus.dm_ack, bus.if_err, bus.dm_err}, 0);
        chk("reset rdata", {bus.if_rdata, bus.dm_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        probe_released("reset bus released", 32'hA5C3_5A3C);

        // Reset in the middle of a DM write
        mem_lat = 255;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0044; bus.dm_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        chk("midrst in access", mem_enable, 1);
        chk("midrst driving", mem_data, 32'hCAFE_F00D);
        rst = 1'b1;
        #1;
        chk("midrst enable", mem_enable, 0);
        chk("midrst busy", busy, 0);
        chk("midrst rnw", mem_readnotwrite, 1);
        probe_released("midrst bus released", 32'h0F0F_1234);
        bus.dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_last_dm = 1'b0;
        both_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dm_ack !== 1'b0 || bus.if_ack !== 1'b0 || busy !== 1'b0) both_bad = 1;
        end
        chk("midrst no ack", both_bad, 0);

        // IF read returning DEADBEEF
        env_mem[16'h0010] = 32'hDEAD_BEEF;
        ref_mem[16'h0010] = 32'hDEAD_BEEF;
        single("if_read", 0, 0, 16'h0010, '0, 2, 0);

        // DM write then readback
        single("dm_write", 1, 1, 16'h0044, 32'h1234_5678, 1, 0);
        single("dm_readback", 1, 0, 16'h0044, '0, 0, 0);
        chk("dm_readback const", ref_read(16'h0044), 32'h1234_5678);

        // Timeout and ready-on-last-cycle
        single("timeout", 0, 0, 16'h0080, '0, 255, 0);
        single("timeout_wr", 1, 1, 16'h0081, 32'h0BAD_0BAD, 255, 0);
        single("ready_at_limit", 1, 0, 16'h0010, '0, TO - 1, 0);

        // Requester drops request mid-access
        single("drop_early", 1, 0, 16'h0044, '0, 4, 1);

        // Spurious DATA_READY while idle
        spur = 1'b1;
        both_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.dm_ack !== 1'b0 || bus.if_ack !== 1'b0 || busy !== 1'b0) both_bad = 1;
        end
        spur = 1'b0;
        @(negedge clk);
        chk("spurious ready ignored", both_bad, 0);

        // Both ports held for four accesses
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last_dm = 1'b0;
        rl = $urandom_range(0, 3);
        mem_lat = rl;
        both_if_addr = 16'h0080;
        both_dm_addr = 16'h0044;
        bus.if_req = 1'b1; bus.if_addr = both_if_addr;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = both_dm_addr;
        edges = 0; acks = 0; last_edge = 0; both_bad = 0;
        while (acks < 4 && edges < 200) begin
            @(negedge clk);
            edges++;
            if (bus.if_ack === 1'b1 && bus.dm_ack === 1'b1) both_bad = 1;
            if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) begin
                exp_dm = !m_last_dm;
                chk($sformatf("both grant%0d", acks), bus.dm_ack, exp_dm);
                chk($sformatf("both rdata%0d", acks), exp_dm ? bus.dm_rdata : bus.if_rdata,
                    ref_read(exp_dm ? both_dm_addr : both_if_addr));
                chk($sformatf("both spacing%0d", acks), edges - last_edge,
                    (acks == 0) ? rl + 2 : rl + 3);
                m_last_dm = exp_dm;
                last_edge = edges;
                acks++;
                if (acks == 4) begin
                    bus.if_req = 1'b0; bus.dm_req = 1'b0;
                end
            end
        end
        chk("both four acks", acks, 4);
        chk("both never dual ack", both_bad, 0);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        chk("both idle after", busy, 0);

        // Randomized single accesses
        for (int i = 0; i < 12; i++) begin
            rdm = 1'($urandom_range(0, 1));
            rwe = rdm ? 1'($urandom_range(0, 1)) : 1'b0;
            ra  = addrs[$urandom_range(0, 3)];
            rw  = $urandom;
            rl  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            single($sformatf("rand%0d", i), rdm, rwe, ra, rw, rl, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
